// File: rtl/csa_final_add.sv
// csa_final_add: resolves a 3-digit carry-save number into binary.
// Define CSA_FINAL_FASTPATH_EN to resolve each digit in one cycle.
module csa_final_add #(
  parameter int N = 222
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N/3-1:0] gin,
  input  logic [N/3-1:0] fin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   result,
  output logic [1:0]     ovf
);

  localparam int DW = N / 3;
  localparam int HW = N / 6;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    dcarry_q, dcarry_d;
  logic [1:0]    ovf_q, ovf_d;
  logic [DW-1:0] g_q, g_d;
  logic [DW-1:0] f_q, f_d;
  logic [N-1:0]  res_q, res_d;
  logic          last;

  assign last = (cnt_q == 2'd2);

`ifdef CSA_FINAL_FASTPATH_EN
  logic [DW+1:0] full;

  assign full = {2'b00, g_q}
              + {1'b0, f_q, 1'b0}
              + {{DW{1'b0}}, dcarry_q};
`else
  logic [1:0]    hc_q, hc_d;
  logic [HW+1:0] lo, hi;

  assign lo = {2'b00, g_q[HW-1:0]}
            + {1'b0, f_q[HW-2:0], 1'b0}
            + {{HW{1'b0}}, dcarry_q};

  // fin[DW-1] carries digit weight 2^DW, i.e. 2^HW in the upper half
  assign hi = {2'b00, g_q[DW-1:HW]}
            + {2'b00, f_q[DW-2:HW-1]}
            + {{HW{1'b0}}, hc_q}
            + {1'b0, f_q[DW-1], {HW{1'b0}}};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dcarry_d = dcarry_q;
    ovf_d    = ovf_q;
    g_d      = g_q;
    f_d      = f_q;
    res_d    = res_q;
`ifndef CSA_FINAL_FASTPATH_EN
    hc_d     = hc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          g_d     = gin;
          f_d     = fin;
          state_d = LO;
        end
      end
`ifdef CSA_FINAL_FASTPATH_EN
      LO: begin
        res_d[int'(cnt_q)*DW +: DW] = full[DW-1:0];
        dcarry_d = full[DW+1:DW];
        if (last) begin
          state_d = DONE;
          cnt_d   = 2'd0;
          ovf_d   = full[DW+1:DW];
        end else begin
          state_d = IDLE;
          cnt_d   = cnt_q + 2'd1;
        end
      end
      HI: state_d = IDLE;
`else
      LO: begin
        res_d[int'(cnt_q)*DW +: HW] = lo[HW-1:0];
        hc_d    = lo[HW+1:HW];
        state_d = HI;
      end
      HI: begin
        res_d[int'(cnt_q)*DW+HW +: HW] = hi[HW-1:0];
        dcarry_d = hi[HW+1:HW];
        if (last) begin
          state_d = DONE;
          cnt_d   = 2'd0;
          ovf_d   = hi[HW+1:HW];
        end else begin
          state_d = IDLE;
          cnt_d   = cnt_q + 2'd1;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d  = IDLE;
          dcarry_d = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      dcarry_q <= 2'd0;
      ovf_q    <= 2'd0;
      g_q      <= '0;
      f_q      <= '0;
      res_q    <= '0;
`ifndef CSA_FINAL_FASTPATH_EN
      hc_q     <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dcarry_q <= dcarry_d;
      ovf_q    <= ovf_d;
      g_q      <= g_d;
      f_q      <= f_d;
      res_q    <= res_d;
`ifndef CSA_FINAL_FASTPATH_EN
      hc_q     <= hc_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa_final_add.sv
// tb_csa_final_add: directed vectors checked against an arithmetic
// model of the three-digit carry-save sum.
module tb_csa_final_add;

  localparam int N  = 222;
  localparam int DW = N / 3;
`ifdef CSA_FINAL_FASTPATH_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef logic [N+3:0] wide_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] gin;
  logic [DW-1:0] fin;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  result;
  logic [1:0]    ovf;

  csa_final_add #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gin       (gin),
    .fin       (fin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int hs_cyc   = 0;

  logic [N-1:0] exp_res  = '0;
  logic [1:0]   exp_ovf  = '0;
  logic         exp_on   = 1'b0;
  logic [N-1:0] last_res;
  logic [1:0]   last_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [N+1:0] act,
                     input logic [N+1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Whole value of the three digits, weighted by 2^(DW*k)
  function automatic void model(input logic [N-1:0] gv,
                                input logic [N-1:0] fv);
    wide_t acc;
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      acc += (wide_t'(gv[k*DW +: DW])
             + (wide_t'(fv[k*DW +: DW]) << 1)) << (k*DW);
    end
    exp_res = acc[N-1:0];
    exp_ovf = acc[N+1:N];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_on && out_valid) begin
        chk("cmp_result", result, exp_res);
        chk("cmp_ovf", ovf, exp_ovf);
        chk("cmp_in_ready_done", in_ready, 1'b0);
      end else if (!exp_on) begin
        chk("cmp_no_valid", out_valid, 1'b0);
      end
    end
  end

  task automatic check_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_result", result, '0);
    chk("rst_ovf", ovf, 2'd0);
  endtask

  task automatic send_digit(input logic [DW-1:0] g,
                            input logic [DW-1:0] f);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1'b1);
    in_valid = 1'b1;
    gin = g;
    fin = f;
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    // garbage offered while busy must be ignored
    gin = DW'({$urandom(), $urandom(), $urandom()});
    fin = DW'({$urandom(), $urandom(), $urandom()});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [N-1:0] gv,
                        input logic [N-1:0] fv,
                        input int hold);
    int n;
    model(gv, fv);
    exp_on = 1'b1;
    for (int k = 0; k < 3; k++)
      send_digit(gv[k*DW +: DW], fv[k*DW +: DW]);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    if (out_valid) chk("latency", cyc - hs_cyc, LAT);
    else chk("out_valid_timeout", out_valid, 1'b1);
    last_res = result;
    last_ovf = ovf;
    repeat (hold) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_result", result, exp_res);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_on = 1'b0;
    chk("pop_valid", out_valid, 1'b0);
    chk("pop_in_ready", in_ready, 1'b1);
    chk("hold_after_pop", result, exp_res);
  endtask

  logic [N-1:0]  gv, fv, lit;
  logic [DW-1:0] ones;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    gin = '0;
    fin = '0;
    ones = '1;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    #1;
    check_reset();

    run_op('0, '0, 0);
    chk("pin_zero_res", last_res, '0);
    chk("pin_zero_ovf", last_ovf, 2'd0);

    gv = '0;
    gv[0] = 1'b1;
    gv[DW] = 1'b1;
    gv[2*DW] = 1'b1;
    run_op(gv, '0, 0);
    lit = '0;
    lit[0] = 1'b1;
    lit[DW] = 1'b1;
    lit[2*DW] = 1'b1;
    chk("pin_ones_res", last_res, lit);
    chk("pin_ones_ovf", last_ovf, 2'd0);

    gv = '0;
    fv = '0;
    gv[DW-1:0] = ones;
    fv[0] = 1'b1;
    run_op(gv, fv, 0);
    lit = '0;
    lit[0] = 1'b1;
    lit[DW] = 1'b1;
    chk("pin_dcarry_res", last_res, lit);
    chk("pin_dcarry_ovf", last_ovf, 2'd0);

    gv = '0;
    fv = '0;
    gv[36:0] = '1;
    fv[0] = 1'b1;
    run_op(gv, fv, 0);
    lit = '0;
    lit[0] = 1'b1;
    lit[37] = 1'b1;
    chk("pin_hcarry_res", last_res, lit);

    gv = '0;
    fv = '0;
    gv[2*DW +: DW] = ones;
    fv[2*DW +: DW] = ones;
    run_op(gv, fv, 5);
    lit = '0;
    lit[2*DW +: DW] = ones - DW'(2);
    chk("pin_top_res", last_res, lit);
    chk("pin_top_ovf", last_ovf, 2'd2);

    gv = {DW'(74'h2AA_AAAA_5555_1234_9876), DW'(74'h3FF_0000_FFFF_0000_FFFF),
          DW'(74'h155_5555_AAAA_CDEF_0123)};
    fv = {DW'(74'h1F0_F0F0_0F0F_F0F0_0F0F), DW'(74'h3FF_FFFF_FFFF_FFFF_FFFF),
          DW'(74'h0AB_CDEF_0123_4567_89AB)};
    run_op(gv, fv, 2);

    exp_on = 1'b0;
    send_digit(DW'(74'h123), DW'(74'h3));
    send_digit(DW'(74'h3FF_FFFF_FFFF_FFFF_FFFF), DW'(74'h7));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset();
    gv = '0;
    gv[0 +: DW] = DW'(5);
    gv[DW +: DW] = DW'(5);
    gv[2*DW +: DW] = DW'(5);
    run_op(gv, '0, 1);
    lit = '0;
    lit[0 +: 3] = 3'd5;
    lit[DW +: 3] = 3'd5;
    lit[2*DW +: 3] = 3'd5;
    chk("pin_rst_res", last_res, lit);
    chk("pin_rst_ovf", last_ovf, 2'd0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
